// File: rtl/logic_op_pkg.sv
// Shared opcode definitions for the logic_op_pipe stage and its datapath.
package logic_op_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OpAnd  = 3'd0,
    OpOr   = 3'd1,
    OpNand = 3'd2,
    OpNor  = 3'd3,
    OpXor  = 3'd4,
    OpXnor = 3'd5,
    OpNot  = 3'd6,
    OpBuf  = 3'd7
  } op_e;

endpackage

// File: rtl/logic_op_comb.sv
// Purely combinational bitwise function unit: y = f_op(a, b).
module logic_op_comb
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = '0;
    unique case (op_e'(i_op))
      OpAnd:  o_y = i_a & i_b;
      OpOr:   o_y = i_a | i_b;
      OpNand: o_y = ~(i_a & i_b);
      OpNor:  o_y = ~(i_a | i_b);
      OpXor:  o_y = i_a ^ i_b;
      OpXnor: o_y = ~(i_a ^ i_b);
      OpNot:  o_y = ~i_a;
      OpBuf:  o_y = i_a;
    endcase
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Handshaked bitwise logic stage: result computed at the input, held in a
// main register plus a skid register so in_ready is registered-state only.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [OP_W-1:0]  out_op,
  output logic             out_zero,
  output logic [CNT_W-1:0] txn_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_main_y, w_main_y_nxt, r_skid_y, w_skid_y_nxt;
  logic [OP_W-1:0]  r_main_op, w_main_op_nxt, r_skid_op, w_skid_op_nxt;
  logic             r_main_zero, w_main_zero_nxt, r_skid_zero, w_skid_zero_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [WIDTH-1:0] w_y;
  logic             w_zero;
  logic             w_accept;
  logic             w_out_hs;

  logic_op_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .i_op (in_op),
    .i_a  (in_a),
    .i_b  (in_b),
    .o_y  (w_y)
  );

  assign w_zero    = (w_y == '0);
  // Gating with rst guarantees no handshake can occur in a reset cycle.
  assign in_ready  = (r_state != StTwo) && !rst;
  assign out_valid = (r_state != StEmpty) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;

  assign out_y     = r_main_y;
  assign out_op    = r_main_op;
  assign out_zero  = r_main_zero;
  assign txn_count = r_cnt;

  always_comb begin
    w_state_nxt     = r_state;
    w_main_y_nxt    = r_main_y;
    w_main_op_nxt   = r_main_op;
    w_main_zero_nxt = r_main_zero;
    w_skid_y_nxt    = r_skid_y;
    w_skid_op_nxt   = r_skid_op;
    w_skid_zero_nxt = r_skid_zero;
    w_cnt_nxt       = w_out_hs ? r_cnt + CNT_W'(1) : r_cnt;

    unique case (r_state)
      StEmpty: begin
        if (w_accept) begin
          w_main_y_nxt    = w_y;
          w_main_op_nxt   = in_op;
          w_main_zero_nxt = w_zero;
          w_state_nxt     = StOne;
        end
      end
      StOne: begin
        if (w_accept && w_out_hs) begin
          w_main_y_nxt    = w_y;
          w_main_op_nxt   = in_op;
          w_main_zero_nxt = w_zero;
        end else if (w_accept) begin
          w_skid_y_nxt    = w_y;
          w_skid_op_nxt   = in_op;
          w_skid_zero_nxt = w_zero;
          w_state_nxt     = StTwo;
        end else if (w_out_hs) begin
          w_state_nxt = StEmpty;
        end
      end
      StTwo: begin
        if (w_out_hs) begin
          w_main_y_nxt    = r_skid_y;
          w_main_op_nxt   = r_skid_op;
          w_main_zero_nxt = r_skid_zero;
          w_state_nxt     = StOne;
        end
      end
      default: w_state_nxt = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StEmpty;
      r_main_y    <= '0;
      r_main_op   <= '0;
      r_main_zero <= 1'b0;
      r_skid_y    <= '0;
      r_skid_op   <= '0;
      r_skid_zero <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_y    <= w_main_y_nxt;
      r_main_op   <= w_main_op_nxt;
      r_main_zero <= w_main_zero_nxt;
      r_skid_y    <= w_skid_y_nxt;
      r_skid_op   <= w_skid_op_nxt;
      r_skid_zero <= w_skid_zero_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench for logic_op_pipe: directed scenarios plus random traffic.
module tb_logic_op_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a, in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [2:0]       out_op;
  logic             out_zero;
  logic [CNT_W-1:0] txn_count;

  logic_op_pipe #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_op    (out_op),
    .out_zero  (out_zero),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [2:0]       op;
    logic             zero;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          model_cnt = 0;
  bit          rand_done = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Truth table per opcode, indexed by {a_bit, b_bit}.
  function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    logic [3:0] tt [8];
    exp_t r;
    tt = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1100};
    for (int i = 0; i < int'(WIDTH); i++) r.y[i] = tt[op][{a[i], b[i]}];
    r.op   = op;
    r.zero = (r.y == '0);
    return r;
  endfunction

  // Monitor: handshakes are decided by values stable at the negative edge.
  exp_t        held;
  bit          prev_stall = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      model_cnt  = 0;
      prev_stall = 0;
    end else begin
      check("txn_count", txn_count, model_cnt[CNT_W-1:0]);
      if (prev_stall && out_valid)
        check("stall_stable", {out_y, out_op, out_zero}, held);
      if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          check("out_y", out_y, e.y);
          check("out_op", out_op, e.op);
          check("out_zero", out_zero, e.zero);
        end
        model_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      held       = {out_y, out_op, out_zero};
    end
  end

  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [WIDTH-1:0] sweep_exp [8];
  int c0;

  initial begin
    sweep_exp = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'hA5};
    rst = 1'b1; in_valid = 1'b1; in_op = 3'd1; in_a = 8'h11; in_b = 8'h22; out_ready = 1'b1;

    // Reset
    tick(2);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_op", out_op, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_txn_count", txn_count, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1 check("in_ready_after_rst", in_ready, 1);

    // Single op
    send(3'd0, 8'hF0, 8'h3C);
    check("single_valid", out_valid, 1);
    check("single_y", out_y, 8'h30);
    check("single_op", out_op, 0);
    check("single_zero", out_zero, 0);
    tick(1);
    check("single_cnt", txn_count, 1);

    // Back-to-back opcode sweep
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 8'hA5, 8'h0F);
      check("sweep_y", out_y, sweep_exp[i]);
    end
    check("sweep_cycles", cyc - c0, 8);
    tick(1);
    check("sweep_cnt", txn_count, 9);

    // Backpressure
    out_ready = 1'b0;
    send(3'd1, 8'h12, 8'h34);
    send(3'd4, 8'h12, 8'h34);
    check("bp_in_ready_low", in_ready, 0);
    in_op = 3'd0; in_a = 8'hFF; in_b = 8'h0F; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_y", out_y, 8'h36);
    end
    out_ready = 1'b1;
    send(3'd0, 8'hFF, 8'h0F);
    tick(3);
    check("bp_drained", out_valid, 0);
    check("bp_cnt", txn_count, 12);

    // Zero flag
    send(3'd4, 8'h77, 8'h77);
    check("zf_xor_y", out_y, 8'h00);
    check("zf_xor_z", out_zero, 1);
    send(3'd7, 8'h00, 8'h5A);
    check("zf_buf_z", out_zero, 1);
    send(3'd6, 8'h00, 8'h5A);
    check("zf_not_y", out_y, 8'hFF);
    check("zf_not_z", out_zero, 0);
    tick(2);

    // Reset mid-operation with two results pending
    out_ready = 1'b0;
    send(3'd1, 8'h0F, 8'hF0);
    send(3'd2, 8'h0F, 8'hF0);
    rst = 1'b1;
    #1 check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_cnt", txn_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("mid_rst_no_ghost", out_valid, 0);
    end

    // Random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          in_valid = 1'b0;
          if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
          send(3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int t = 0; t < 100 && (q.size() != 0 || out_valid); t++) tick(1);
    check("final_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
